// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_responder
//  Description : LC-3 memory / memory-mapped I/O responder with programmable
//                wait states and a one-cycle Mem_Ready completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_responder #(
    parameter int          MEM_AW      = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] Switches,
    output logic [15:0] MDR_In,
    output logic        Mem_Ready,
    output logic        Busy,
    output logic [15:0] Hex_Data
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);
    localparam int         c_DEPTH     = 1 << MEM_AW;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_sw;
    logic        r_is_write;
    logic        r_ready;
    logic [15:0] r_mdr_in;
    logic [15:0] r_hex;
    logic [15:0] r_mem [c_DEPTH];

    logic [1:0]        w_next_state;
    logic [3:0]        w_next_cnt;
    logic              w_capture;
    logic [15:0]       w_addr;
    logic [15:0]       w_wdata;
    logic [15:0]       w_sw;
    logic              w_is_write;
    logic              w_is_io;
    logic              w_enter_resp;
    logic [MEM_AW-1:0] w_idx;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (WE || OE) begin
                    w_capture    = 1'b1;
                    w_next_cnt   = c_WAIT_INIT;
                    w_next_state = (WAIT_STATES == 0) ? c_ST_RESP : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next_state = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // With zero wait states the commit happens on the capture edge itself,
    // so the request fields must bypass the capture registers.
    assign w_addr       = w_capture ? MAR      : r_addr;
    assign w_wdata      = w_capture ? MDR      : r_wdata;
    assign w_sw         = w_capture ? Switches : r_sw;
    assign w_is_write   = w_capture ? WE       : r_is_write;
    assign w_is_io      = (w_addr == IO_ADDR);
    assign w_idx        = w_addr[MEM_AW-1:0];
    assign w_enter_resp = (w_next_state == c_ST_RESP) && (r_state != c_ST_RESP) && !Reset;

    always_ff @(posedge Clk) begin
        if (w_enter_resp && w_is_write && !w_is_io) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_sw       <= 16'h0000;
            r_is_write <= 1'b0;
            r_ready    <= 1'b0;
            r_mdr_in   <= 16'h0000;
            r_hex      <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            // Ready trails the RESP state by one edge, so it is seen in the
            // cycle the FSM is already back in IDLE.
            r_ready <= (r_state == c_ST_RESP);
            if (w_capture) begin
                r_addr     <= MAR;
                r_wdata    <= MDR;
                r_sw       <= Switches;
                r_is_write <= WE;
            end
            if (w_enter_resp) begin
                if (w_is_write) begin
                    if (w_is_io) begin
                        r_hex <= w_wdata;
                    end
                end else begin
                    r_mdr_in <= w_is_io ? w_sw : r_mem[w_idx];
                end
            end
        end
    end

    assign MDR_In    = r_mdr_in;
    assign Mem_Ready = r_ready;
    assign Busy      = (r_state != c_ST_IDLE);
    assign Hex_Data  = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_mem_responder
//  Description : Directed self-checking bench for lc3_mem_responder (default
//                wait states and a zero-wait-state instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] MAR = 16'h0000;
    logic [15:0] MDR = 16'h0000;
    logic [15:0] Switches = 16'h0000;
    logic        d_oe = 1'b0, d_we = 1'b0, z_oe = 1'b0, z_we = 1'b0;
    logic [15:0] d_mdr_in, d_hex, z_mdr_in, z_hex;
    logic        d_ready, d_busy, z_ready, z_busy;
    logic        use_z = 1'b0;
    logic        m_ready, m_busy;
    logic [15:0] m_mdr_in;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign m_ready  = use_z ? z_ready  : d_ready;
    assign m_busy   = use_z ? z_busy   : d_busy;
    assign m_mdr_in = use_z ? z_mdr_in : d_mdr_in;

    lc3_mem_responder dut (
        .Clk(clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .OE(d_oe), .WE(d_we),
        .Switches(Switches), .MDR_In(d_mdr_in), .Mem_Ready(d_ready),
        .Busy(d_busy), .Hex_Data(d_hex)
    );

    lc3_mem_responder #(.WAIT_STATES(0)) dut_z (
        .Clk(clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .OE(z_oe), .WE(z_we),
        .Switches(Switches), .MDR_In(z_mdr_in), .Mem_Ready(z_ready),
        .Busy(z_busy), .Hex_Data(z_hex)
    );

    // One transaction: strobe for the capture edge only, then scramble the
    // request inputs and measure latency, busy length and pulse width.
    task automatic run_req(input logic we, input logic oe, input logic [15:0] addr,
                           input logic [15:0] data, input logic [15:0] sw_after,
                           output int lat, output int busy_n, output logic width_ok,
                           output logic [15:0] hex_at_rdy);
        @(negedge clk);
        MAR = addr;
        MDR = data;
        if (use_z) begin z_we = we; z_oe = oe; end
        else       begin d_we = we; d_oe = oe; end
        @(posedge clk); #1;
        d_we = 1'b0; d_oe = 1'b0; z_we = 1'b0; z_oe = 1'b0;
        Switches = sw_after;
        MAR = 16'h1111;
        MDR = 16'h2222;
        busy_n = m_busy ? 1 : 0;
        lat = 0;
        hex_at_rdy = 16'hxxxx;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (m_busy) busy_n++;
            if (m_ready) begin lat = k; hex_at_rdy = d_hex; end
        end
        @(posedge clk); #1;
        width_ok = !m_ready;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", d_ready); end
        n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", d_busy); end
        n_cmp++; if (d_mdr_in !== 16'h0000) begin n_bad++; $display("FAIL reset_mdr_in: got %h want 0000", d_mdr_in); end
        n_cmp++; if (d_hex !== 16'h0000) begin n_bad++; $display("FAIL reset_hex: got %h want 0000", d_hex); end
        Reset = 1'b0;
    endtask

    task automatic test_write_read();
        int lat, bn; logic wok; logic [15:0] hx;
        run_req(1'b1, 1'b0, 16'h0005, 16'h1234, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        n_cmp++; if (bn !== 3) begin n_bad++; $display("FAIL wr_busy_cycles: got %0d want 3", bn); end
        n_cmp++; if (wok !== 1'b1) begin n_bad++; $display("FAIL wr_pulse_width: got %b want 1", wok); end
        n_cmp++; if (d_mdr_in !== 16'h0000) begin n_bad++; $display("FAIL wr_mdr_in_kept: got %h want 0000", d_mdr_in); end
        run_req(1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (bn !== 3) begin n_bad++; $display("FAIL rd_busy_cycles: got %0d want 3", bn); end
        n_cmp++; if (d_mdr_in !== 16'h1234) begin n_bad++; $display("FAIL rd_data: got %h want 1234", d_mdr_in); end
    endtask

    task automatic test_io_read();
        int lat, bn; logic wok; logic [15:0] hx;
        Switches = 16'hBEEF;
        run_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL io_rd_latency: got %0d want 3", lat); end
        n_cmp++; if (d_mdr_in !== 16'hBEEF) begin n_bad++; $display("FAIL io_rd_data: got %h want beef", d_mdr_in); end
    endtask

    task automatic test_io_write();
        int lat, bn; logic wok; logic [15:0] hx;
        run_req(1'b1, 1'b0, 16'h03FF, 16'h7777, 16'h0000, lat, bn, wok, hx);
        run_req(1'b1, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (hx !== 16'h00A5) begin n_bad++; $display("FAIL io_wr_hex: got %h want 00a5", hx); end
        n_cmp++; if (d_mdr_in !== 16'hBEEF) begin n_bad++; $display("FAIL io_wr_mdr_in_kept: got %h want beef", d_mdr_in); end
        run_req(1'b0, 1'b1, 16'h03FF, 16'h0000, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (d_mdr_in !== 16'h7777) begin n_bad++; $display("FAIL io_wr_array_untouched: got %h want 7777", d_mdr_in); end
    endtask

    task automatic test_priority_alias();
        int lat, bn; logic wok; logic [15:0] hx;
        run_req(1'b1, 1'b1, 16'h0400, 16'hCAFE, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL prio_latency: got %0d want 3", lat); end
        n_cmp++; if (d_mdr_in !== 16'h7777) begin n_bad++; $display("FAIL prio_mdr_in_kept: got %h want 7777", d_mdr_in); end
        run_req(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (d_mdr_in !== 16'hCAFE) begin n_bad++; $display("FAIL alias_rd_data: got %h want cafe", d_mdr_in); end
    endtask

    task automatic test_reset_abort();
        int lat, bn; logic wok; logic [15:0] hx; logic seen;
        run_req(1'b1, 1'b0, 16'h0010, 16'h1111, 16'h0000, lat, bn, wok, hx);
        // Reset on the first WAIT edge, then again exactly on the commit edge.
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            MAR = 16'h0010; MDR = 16'h5555; d_we = 1'b1;
            @(posedge clk); #1;
            d_we = 1'b0;
            if (pass == 1) begin @(posedge clk); #1; end
            Reset = 1'b1;
            @(posedge clk); #1;
            Reset = 1'b0;
            n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy[%0d]: got %b want 0", pass, d_busy); end
            seen = d_ready;
            repeat (5) begin @(posedge clk); #1; if (d_ready) seen = 1'b1; end
            n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_ready[%0d]: got %b want 0", pass, seen); end
        end
        run_req(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (d_mdr_in !== 16'h1111) begin n_bad++; $display("FAIL abort_old_value: got %h want 1111", d_mdr_in); end
    endtask

    task automatic test_zero_wait();
        int lat, bn; logic wok; logic [15:0] hx; logic [5:0] pat;
        use_z = 1'b1;
        run_req(1'b1, 1'b0, 16'h0003, 16'hABCD, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL z_wr_latency: got %0d want 1", lat); end
        run_req(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0000, lat, bn, wok, hx);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL z_rd_latency: got %0d want 1", lat); end
        n_cmp++; if (bn !== 1) begin n_bad++; $display("FAIL z_busy_cycles: got %0d want 1", bn); end
        n_cmp++; if (m_mdr_in !== 16'hABCD) begin n_bad++; $display("FAIL z_rd_data: got %h want abcd", m_mdr_in); end
        @(negedge clk);
        MAR = 16'h0003; z_oe = 1'b1;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; pat[i] = z_ready; end
        z_oe = 1'b0;
        n_cmp++; if (pat !== 6'b101010) begin n_bad++; $display("FAIL z_back_to_back: got %b want 101010", pat); end
        repeat (3) @(posedge clk);
        use_z = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_io_read();
        test_io_write();
        test_priority_alias();
        test_reset_abort();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
